stream_mac: RTL
===============

# stream_mac

Signed multiply-accumulate stage placed directly downstream of `stream_join`. It consumes the joined `{left, right}` operand beats, forms `left * right` as signed values, and accumulates `K_LEN` consecutive products. Each completed dot product is emitted as a single beat on a valid/ready output stream, so the GEMM datapath gets one result per `K_LEN` operand pairs.

## Interface
- `A_WIDTH`, default 8: width of the left operand (upper bits of `i_data`), signed.
- `B_WIDTH`, default 8: width of the right operand (lower bits of `i_data`), signed.
- `ACC_WIDTH`, default 32: width of the accumulator and of `o_data`. Must be ≥ `A_WIDTH + B_WIDTH`.
- `K_LEN`, default 4: number of beats per dot product. Must be ≥ 1.
- `IN_WIDTH`, default `A_WIDTH + B_WIDTH`: width of the input data.
- `clk`  in  1  the single clock; all logic is on `posedge clk`.
- `reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  input beat valid.
- `i_ready`  out  1  input beat accepted when `i_valid && i_ready`.
- `i_data`  in  `IN_WIDTH`  `{a[A_WIDTH-1:0], b[B_WIDTH-1:0]}`.
- `o_valid`  out  1  result valid.
- `o_ready`  in  1  downstream ready.
- `o_data`  out  `ACC_WIDTH`  dot-product result, two's complement.

## Operation
- State:
  - beat counter `cnt` in 0..`K_LEN-1`; width `max(1, $clog2(K_LEN))`.
  - accumulator `acc[ACC_WIDTH-1:0]`.
  - one-entry output register (`o_valid`, `o_data`).
- Product: `a` and `b` are sign-extended and multiplied. The full `A_WIDTH+B_WIDTH` product is sign-extended to `ACC_WIDTH` and added to `acc`.
- Accepted beat, `cnt < K_LEN-1`:
  - `acc <= acc + p`
  - `cnt <= cnt + 1`
- Accepted beat, `cnt == K_LEN-1` (the last beat):
  - output register loads `acc + p`.
  - `acc <= 0`
  - `cnt <= 0`
- `i_ready = (cnt != K_LEN-1) || !o_valid || o_ready`.
  - Non-last beats are never back-pressured.
  - The last beat needs the output slot to be empty, or draining in the same cycle.
- Output handshake:
  - `o_valid` clears on `o_valid && o_ready` unless a new last beat loads in the same cycle. A simultaneous drain and load keeps `o_valid` high with the new data.
  - While `o_valid && !o_ready`, `o_valid` and `o_data` are held stable.
  - `o_data` is 0 whenever `o_valid` is low.
- `K_LEN == 1`: every beat is a last beat; `o_data` is that beat's product.
- Default arithmetic wraps modulo 2^`ACC_WIDTH`.

## Timing
- Reset (takes effect at the clock edge where `reset` is high) clears:
  - `cnt = 0`, `acc = 0`
  - `o_valid = 0`, `o_data = 0`
  - `i_ready = 1` after reset.
- Reset mid-operation discards the partial sum and any pending result, with no output beat.
- `i_valid` and `i_ready` are ignored in the reset cycle.
- Latency: last beat accepted at edge t gives `o_valid` high in the cycle after t (one register stage).
- Throughput: one input beat per cycle when `o_ready` is held high; back-to-back dot products have no bubbles.
- No combinational path from `i_valid` to `i_ready`.
- `i_ready` depends combinationally on `o_ready` only in the last-beat state.

## Configuration
- `STREAM_MAC_SATURATE_EN` defined:
  - each accumulation step saturates to the signed range: max `2^(ACC_WIDTH-1)-1`, min `-2^(ACC_WIDTH-1)`.
  - overflow is detected from the operand and result sign bits.
  - once saturated, a later addition of the opposite sign moves the value off the rail normally.
- Undefined: the accumulator wraps modulo 2^`ACC_WIDTH` and there is no saturation logic.

## Test plan
- Default params, `o_ready=1`, pairs (1,2),(3,4),(5,6),(7,8) back-to-back → one beat `o_data=100` the cycle after the 4th accept; `i_ready` high throughout.
- Signed: four beats `i_data=16'hFF02` (-1×2) → `o_data=32'hFFFFFFF8` (-8).
- Stall: `o_ready=0` with result 100 pending, then 4 more beats of (1,1):
  - first 3 accepted; 4th sees `i_ready=0` until `o_ready` rises.
  - `o_data` stays 100 while stalled.
  - next result is 4, one cycle after the 4th beat is accepted.
- Reset after 2 accepted beats of (10,10), then 4 beats of (1,1) → only output is `o_data=4`; `o_valid=0` and `o_data=0` during and after reset.
- `ACC_WIDTH=16`, four beats of (127,127):
  - without macro: `o_data=16'hFC04`.
  - with `STREAM_MAC_SATURATE_EN`: `o_data=16'h7FFF`.
- 8 beats of (2,3), `o_ready=1` → two results of 24 on consecutive 4-cycle boundaries; `i_ready` never low.

Source files
------------

// File: rtl/stream_mac.sv
// Signed multiply-accumulate over K_LEN operand beats, one dot-product result per output beat.
// Optional: define STREAM_MAC_SATURATE_EN to clamp each accumulation step to the signed range.
module stream_mac #(
   parameter int A_WIDTH   = 8,
   parameter int B_WIDTH   = 8,
   parameter int ACC_WIDTH = 32,
   parameter int K_LEN     = 4,
   parameter int IN_WIDTH  = A_WIDTH + B_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_valid,
   output logic                 i_ready,
   input  logic [IN_WIDTH-1:0]  i_data,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [ACC_WIDTH-1:0] o_data
);
   localparam int CNT_W   = (K_LEN > 1) ? $clog2(K_LEN) : 1;
   localparam int P_WIDTH = A_WIDTH + B_WIDTH;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K_LEN - 1);

   logic [CNT_W-1:0]            cnt_reg;
   logic [ACC_WIDTH-1:0]        acc_reg;
   logic                        o_valid_reg;
   logic [ACC_WIDTH-1:0]        o_data_reg;

   logic signed [A_WIDTH-1:0]   a_val;
   logic signed [B_WIDTH-1:0]   b_val;
   logic signed [P_WIDTH-1:0]   prod;
   logic signed [ACC_WIDTH-1:0] prod_ext;
   logic [ACC_WIDTH-1:0]        sum_wrap;
   logic [ACC_WIDTH-1:0]        sum_next;
   logic                        last_beat;
   logic                        accept;

   assign a_val    = i_data[P_WIDTH-1:B_WIDTH];
   assign b_val    = i_data[B_WIDTH-1:0];
   assign prod     = a_val * b_val;
   assign prod_ext = ACC_WIDTH'(prod);
   assign sum_wrap = acc_reg + prod_ext;

`ifdef STREAM_MAC_SATURATE_EN
   localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   logic overflow;

   // Overflow only when both addends share a sign and the result flips it.
   assign overflow = (acc_reg[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                     (sum_wrap[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);
   assign sum_next = overflow ? (acc_reg[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX) : sum_wrap;
`else
   assign sum_next = sum_wrap;
`endif

   assign last_beat = (cnt_reg == LAST_CNT);
   // Only the final beat waits for the output slot; o_ready enters only via that term.
   assign i_ready   = !last_beat || !o_valid_reg || o_ready;
   assign accept    = i_valid && i_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg     <= '0;
         acc_reg     <= '0;
         o_valid_reg <= 1'b0;
         o_data_reg  <= '0;
      end else begin
         if (o_valid_reg && o_ready) begin
            o_valid_reg <= 1'b0;
            o_data_reg  <= '0;
         end
         if (accept) begin
            if (last_beat) begin
               o_valid_reg <= 1'b1;
               o_data_reg  <= sum_next;
               acc_reg     <= '0;
               cnt_reg     <= '0;
            end else begin
               acc_reg <= sum_next;
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   end

   assign o_valid = o_valid_reg;
   assign o_data  = o_data_reg;
endmodule
